// File: rtl/reset_router_pkg.sv
// Shared types and default sizing for the per-design reset sequencer.
package reset_router_pkg;

    typedef enum logic [1:0] {
        IN_RESET = 2'd0,
        HOLD     = 2'd1,
        RUN      = 2'd2
    } chan_state_t;

    localparam int unsigned DEF_NUM_DESIGNS = 12;
    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_HOLD_CYCLES = 16;

endpackage

// File: rtl/reset_channel.sv
// One design reset channel: held while its cause is active, then stretched for
// HOLD_CYCLES clean cycles before release.
module reset_channel
    import reset_router_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic clk,
    input  logic n_rst,
    input  logic cause,
    output logic n_rst_out,
    output logic in_hold,
    output logic in_run
);

    localparam int unsigned CW = $clog2(HOLD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_CYCLES - 1);

    chan_state_t   state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        case (state_q)
            IN_RESET: begin
                if (!cause) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // Any cause aborts the hold; the count restarts from zero next time.
                if (cause) begin
                    state_d = IN_RESET;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                if (cause) begin
                    state_d = IN_RESET;
                end
            end
            default: state_d = IN_RESET;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IN_RESET;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            run_q   <= (state_d == RUN);
        end
    end

    // Dedicated flop keeps the design reset free of any decode glitches.
    assign n_rst_out = run_q;
    // Next-state views so the top-level status registers align with n_rst_out.
    assign in_hold   = (state_d == HOLD);
    assign in_run    = (state_d == RUN);

endmodule

// File: rtl/reset_sequencer.sv
// Per-design reset generator: global reset synchroniser, per-channel cause logic,
// channel FSMs and registered status (busy flag, running-channel count).
module reset_sequencer
    import reset_router_pkg::*;
#(
    parameter int unsigned NUM_DESIGNS = DEF_NUM_DESIGNS,
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic                               clk,
    input  logic                               n_rst,
    input  logic [NUM_DESIGNS:1]               designs_cs,
    input  logic [NUM_DESIGNS:1]               sw_rst,
    output logic [NUM_DESIGNS:1]               designs_n_rst,
    output logic                               rst_busy,
    output logic [$clog2(NUM_DESIGNS+1)-1:0]   active_count
);

    localparam int unsigned ACW = $clog2(NUM_DESIGNS + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   g_rst_n;
    logic [NUM_DESIGNS:1]   cause;
    logic [NUM_DESIGNS:1]   hold_next;
    logic [NUM_DESIGNS:1]   run_next;
    logic [ACW-1:0]         run_cnt;
    logic                   rst_busy_q;
    logic [ACW-1:0]         active_count_q;

    // Async assert, sync deassert of the chip reset.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign g_rst_n = sync_q[SYNC_STAGES-1];

    always_comb begin
        cause = designs_cs | sw_rst | {NUM_DESIGNS{~g_rst_n}};
    end

    for (genvar i = 1; i <= NUM_DESIGNS; i++) begin : g_chan
        reset_channel #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_chan (
            .clk       (clk),
            .n_rst     (n_rst),
            .cause     (cause[i]),
            .n_rst_out (designs_n_rst[i]),
            .in_hold   (hold_next[i]),
            .in_run    (run_next[i])
        );
    end

    always_comb begin
        run_cnt = '0;
        for (int unsigned i = 1; i <= NUM_DESIGNS; i++) begin
            run_cnt = run_cnt + ACW'(run_next[i]);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rst_busy_q     <= 1'b0;
            active_count_q <= '0;
        end else begin
            rst_busy_q     <= |hold_next;
            active_count_q <= run_cnt;
        end
    end

    assign rst_busy     = rst_busy_q;
    assign active_count = active_count_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default instance plus a small parametrised one.
module tb_reset_sequencer;

    logic        clk = 1'b0;
    logic        clk_en = 1'b1;
    logic        n_rst = 1'b0;
    logic        n_rst2 = 1'b0;
    logic [12:1] designs_cs = 12'hFFF;
    logic [12:1] sw_rst = '0;
    logic [12:1] designs_n_rst;
    logic        rst_busy;
    logic [3:0]  active_count;
    logic [4:1]  designs_cs2 = 4'h0;
    logic [4:1]  sw_rst2 = 4'h0;
    logic [4:1]  designs_n_rst2;
    logic        rst_busy2;
    logic [2:0]  active_count2;

    int checks = 0;
    int errors = 0;

    always #5 if (clk_en) clk = ~clk;

    reset_sequencer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .designs_cs    (designs_cs),
        .sw_rst        (sw_rst),
        .designs_n_rst (designs_n_rst),
        .rst_busy      (rst_busy),
        .active_count  (active_count)
    );

    reset_sequencer #(
        .NUM_DESIGNS (4),
        .SYNC_STAGES (3),
        .HOLD_CYCLES (1)
    ) dut2 (
        .clk           (clk),
        .n_rst         (n_rst2),
        .designs_cs    (designs_cs2),
        .sw_rst        (sw_rst2),
        .designs_n_rst (designs_n_rst2),
        .rst_busy      (rst_busy2),
        .active_count  (active_count2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        // 1: power-on with only channel 3 deselected
        designs_cs = 12'hFFB;
        repeat (5) tick();
        chk("t1_reset_n_rst", 32'(designs_n_rst), 32'h0);
        chk("t1_reset_busy", 32'(rst_busy), 32'h0);
        chk("t1_reset_count", 32'(active_count), 32'h0);
        chk("t5_reset_n_rst", 32'(designs_n_rst2), 32'h0);
        n_rst = 1'b1;
        for (int e = 1; e <= 20; e++) begin
            tick();
            chk($sformatf("t1_n_rst_e%0d", e), 32'(designs_n_rst), (e >= 19) ? 32'h004 : 32'h0);
            chk($sformatf("t1_busy_e%0d", e), 32'(rst_busy),
                (e >= 3 && e <= 18) ? 32'h1 : 32'h0);
            chk($sformatf("t1_count_e%0d", e), 32'(active_count), (e >= 19) ? 32'h1 : 32'h0);
        end

        // 2: async assert with clock stopped
        designs_cs = 12'h000;
        repeat (20) tick();
        chk("t2_all_run", 32'(designs_n_rst), 32'hFFF);
        chk("t2_all_count", 32'(active_count), 32'd12);
        clk_en = 1'b0;
        #2;
        n_rst = 1'b0;
        #1;
        chk("t2_async_n_rst", 32'(designs_n_rst), 32'h0);
        chk("t2_async_busy", 32'(rst_busy), 32'h0);
        chk("t2_async_count", 32'(active_count), 32'h0);
        #10;
        clk_en = 1'b1;
        tick();

        // 3: aborted hold on channel 5
        designs_cs = 12'hFFF;
        n_rst = 1'b1;
        repeat (5) tick();
        designs_cs[5] = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            tick();
            chk($sformatf("t3_window_e%0d", e), 32'(designs_n_rst[5]), 32'h0);
        end
        chk("t3_window_busy", 32'(rst_busy), 32'h1);
        designs_cs[5] = 1'b1;
        tick();
        chk("t3_abort_n_rst", 32'(designs_n_rst[5]), 32'h0);
        chk("t3_abort_busy", 32'(rst_busy), 32'h0);
        designs_cs[5] = 1'b0;
        for (int e = 0; e <= 15; e++) begin
            tick();
            chk($sformatf("t3_rehold_e%0d", e), 32'(designs_n_rst[5]), 32'h0);
        end
        tick();
        chk("t3_release", 32'(designs_n_rst), 32'h010);

        // 4: software reset pulse on channel 3 (channel 5 must stay up)
        designs_cs[3] = 1'b0;
        repeat (17) tick();
        chk("t4_ch3_run", 32'(designs_n_rst), 32'h014);
        sw_rst[3] = 1'b1;
        tick();
        chk("t4_sw_edge", 32'(designs_n_rst), 32'h010);
        chk("t4_sw_count", 32'(active_count), 32'h1);
        sw_rst[3] = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk($sformatf("t4_hold_e%0d", e), 32'(designs_n_rst), 32'h010);
        end
        tick();
        chk("t4_release", 32'(designs_n_rst), 32'h014);
        chk("t4_count", 32'(active_count), 32'h2);

        // 6: channels 1, 2, 7 released together
        designs_cs = 12'hFFF;
        tick();
        chk("t6_all_held", 32'(designs_n_rst), 32'h0);
        designs_cs = 12'hFBC;
        for (int e = 1; e <= 16; e++) begin
            tick();
            chk($sformatf("t6_hold_e%0d", e), 32'(designs_n_rst), 32'h0);
        end
        tick();
        chk("t6_release", 32'(designs_n_rst), 32'h043);
        chk("t6_count3", 32'(active_count), 32'h3);
        designs_cs[2] = 1'b1;
        tick();
        chk("t6_drop_n_rst", 32'(designs_n_rst), 32'h041);
        chk("t6_count2", 32'(active_count), 32'h2);

        // 5: parametrised instance (4 designs, 3 sync stages, hold 1)
        n_rst2 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            tick();
            chk($sformatf("t5_n_rst_e%0d", e), 32'(designs_n_rst2), (e >= 5) ? 32'hF : 32'h0);
            chk($sformatf("t5_count_e%0d", e), 32'(active_count2), (e >= 5) ? 32'h4 : 32'h0);
            chk($sformatf("t5_busy_e%0d", e), 32'(rst_busy2), (e == 4) ? 32'h1 : 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
